// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - FSM state enum
//   - lsu_fault(): misalignment / illegal-encoding check for a request
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RMW_WRITE = 2'd1,
      S_RESP      = 2'd2
   } lsu_state_t;

   // 1 when the request must not touch memory: unaligned halfword/word,
   // reserved funct3 (3,6,7), or an unsigned-load encoding used as a store.
   function automatic logic lsu_fault(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
      case (f3)
         F3_B:    return 1'b0;
         F3_BU:   return we;
         F3_H:    return off[0];
         F3_HU:   return we | off[0];
         F3_W:    return off != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational data alignment for the load/store unit.
//   funct3    in  access size/sign
//   byte_off  in  byte address bits [1:0]
//   rdata     in  word read from memory
//   wdata     in  store data (low byte/halfword used for SB/SH)
//   load_data out extracted and sign/zero-extended load result
//   merged    out rdata with the store byte lane(s) replaced by wdata
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [31:0] shifted;
   logic [7:0]  lbyte;
   logic [15:0] lhalf;
   logic [3:0]  be;
   logic [31:0] wrep;

   assign shifted = rdata >> {byte_off, 3'b000};
   assign lbyte   = shifted[7:0];
   assign lhalf   = byte_off[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      load_data = rdata;
      case (funct3)
         F3_B:    load_data = {{24{lbyte[7]}}, lbyte};
         F3_BU:   load_data = {24'd0, lbyte};
         F3_H:    load_data = {{16{lhalf[15]}}, lhalf};
         F3_HU:   load_data = {16'd0, lhalf};
         default: load_data = rdata;
      endcase
   end

   // Replicate the store data across all lanes, then pick lanes by byte enable.
   always_comb begin
      be   = 4'b1111;
      wrep = wdata;
      case (funct3[1:0])
         2'b00: begin
            be   = 4'b0001 << byte_off;
            wrep = {4{wdata[7:0]}};
         end
         2'b01: begin
            be   = byte_off[1] ? 4'b1100 : 4'b0011;
            wrep = {2{wdata[15:0]}};
         end
         default: begin
            be   = 4'b1111;
            wrep = wdata;
         end
      endcase
      merged = rdata;
      for (int i = 0; i < 4; i++)
         if (be[i]) merged[8*i +: 8] = wrep[8*i +: 8];
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage port between the pipeline and a word-addressed
// single-port data memory.
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (accept = both high)
//   req_we/funct3/addr/wdata    request fields, sampled only at accept
//   resp_valid                  one-cycle completion pulse
//   resp_rdata/resp_fault       result, held until the next response
//   mem_write_en/addr/write_data, mem_read_data   data memory port
// Loads, SW and faults respond one cycle after accept. SB/SH read the old
// word at accept and write the merged word in RMW_WRITE.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_write_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   lsu_state_t            state;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [31:0]           merged_q;

   logic                  accept;
   logic                  fault;
   logic                  subword_st;
   logic [ADDR_WIDTH-1:0] req_idx;
   logic [31:0]           load_data;
   logic [31:0]           merged;
   logic                  unused_addr;

   assign req_idx     = req_addr[ADDR_WIDTH+1:2];
   assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
   assign req_ready   = rst_n & (state == S_IDLE);
   assign accept      = req_valid & req_ready;
   assign fault       = lsu_fault(req_we, req_funct3, req_addr[1:0]);
   assign subword_st  = req_we & (req_funct3 != F3_W);

   lsu_align u_align (
      .funct3    (req_funct3),
      .byte_off  (req_addr[1:0]),
      .rdata     (mem_read_data),
      .wdata     (req_wdata),
      .load_data (load_data),
      .merged    (merged)
   );

   // SW writes straight through in the accept cycle; SB/SH write in RMW_WRITE.
   // rst_n gating kills a write already in flight when reset hits mid-RMW.
   assign mem_write_en   = rst_n & ((accept & req_we & ~fault & ~subword_st) |
                                    (state == S_RMW_WRITE));
   assign mem_addr       = (state == S_IDLE) ? 32'(req_idx) : 32'(idx_q);
   assign mem_write_data = (state == S_RMW_WRITE) ? merged_q : req_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_fault <= 1'b0;
         idx_q      <= '0;
         merged_q   <= 32'd0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  idx_q <= req_idx;
                  if (fault) begin
                     resp_rdata <= 32'd0;
                     resp_fault <= 1'b1;
                     resp_valid <= 1'b1;
                     state      <= S_RESP;
                  end else if (subword_st) begin
                     // response registers untouched until the write completes
                     merged_q <= merged;
                     state    <= S_RMW_WRITE;
                  end else begin
                     resp_rdata <= req_we ? 32'd0 : load_data;
                     resp_fault <= 1'b0;
                     resp_valid <= 1'b1;
                     state      <= S_RESP;
                  end
               end
            end
            S_RMW_WRITE: begin
               resp_rdata <= 32'd0;
               resp_fault <= 1'b0;
               resp_valid <= 1'b1;
               state      <= S_RESP;
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven bench with a response scoreboard and a
// behavioural data memory, plus sequences for reset-in-RMW and back-to-back.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_write_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:65535];
   int          wr_cnt;
   int          tests;
   int          fails;
   logic [32:0] sb_q[$];
   wire         unused_tb = ^mem_addr[31:16];

   load_store_unit #(.ADDR_WIDTH(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_fault     (resp_fault),
      .mem_write_en   (mem_write_en),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_addr[15:0]];

   initial wr_cnt = 0;
   always @(posedge clk) begin
      if (mem_write_en) begin
         mem[mem_addr[15:0]] <= mem_write_data;
         wr_cnt <= wr_cnt + 1;
      end
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_f;
      int          lat;
      int          nwr;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vt[17];
   vec_t bb[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: timeout, got no event expected event", nm);
   endtask

   task automatic drive(input vec_t v);
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
   endtask

   task automatic scramble();
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int          wr0;
      int          lat;
      logic [32:0] e;
      @(posedge clk); #1;
      drive(v);
      req_valid = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!req_ready && lat < 8);
      if (!req_ready) begin
         fail_now({nm, " accept"});
         scramble();
         return;
      end
      wr0 = wr_cnt;
      chk({nm, " accept_wen"}, 32'(mem_write_en), 32'(v.nwr == 1 && v.lat == 1));
      sb_q.push_back({v.exp_rd, v.exp_f});
      @(posedge clk); #1;
      scramble();
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1 && v.lat == 2)
            chk({nm, " rmw_wen"}, 32'(mem_write_en), 32'(v.nwr));
         if (!resp_valid) chk({nm, " busy_ready"}, 32'(req_ready), 32'd0);
      end while (!resp_valid && lat < 8);
      if (!resp_valid) begin
         fail_now({nm, " resp"});
         void'(sb_q.pop_front());
         return;
      end
      chk({nm, " latency"}, 32'(lat), 32'(v.lat));
      e = sb_q.pop_front();
      chk({nm, " rdata"}, resp_rdata, e[32:1]);
      chk({nm, " fault"}, 32'(resp_fault), 32'(e[0]));
      chk({nm, " writes"}, 32'(wr_cnt - wr0), 32'(v.nwr));
      chk({nm, " word"}, mem[v.addr[17:2]], v.exp_word);
   endtask

   initial begin
      int          idx;
      int          nresp;
      int          cyc;
      int          last_acc;
      int          wr0;
      logic        acc;
      logic [32:0] e;

      tests = 0;
      fails = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 32'd0;

      //        we    f3    addr       wdata          exp_rd        f    lat nwr word
      vt[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h00000000, 1'b0, 1, 1, 32'hDEADBEEF};
      vt[1]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 1, 0, 32'hDEADBEEF};
      vt[2]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'hFFFFFFDE, 1'b0, 1, 0, 32'hDEADBEEF};
      vt[3]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h000000DE, 1'b0, 1, 0, 32'hDEADBEEF};
      vt[4]  = '{1'b0, 3'd1, 32'h100, 32'h0,        32'hFFFFBEEF, 1'b0, 1, 0, 32'hDEADBEEF};
      vt[5]  = '{1'b0, 3'd5, 32'h102, 32'h0,        32'h0000DEAD, 1'b0, 1, 0, 32'hDEADBEEF};
      vt[6]  = '{1'b1, 3'd0, 32'h101, 32'hFFFFFF12, 32'h00000000, 1'b0, 2, 1, 32'hDEAD12EF};
      vt[7]  = '{1'b1, 3'd1, 32'h102, 32'hABCD3456, 32'h00000000, 1'b0, 2, 1, 32'h345612EF};
      vt[8]  = '{1'b1, 3'd2, 32'h102, 32'hCAFEF00D, 32'h00000000, 1'b1, 1, 0, 32'h345612EF};
      vt[9]  = '{1'b0, 3'd1, 32'h101, 32'h0,        32'h00000000, 1'b1, 1, 0, 32'h345612EF};
      vt[10] = '{1'b0, 3'd3, 32'h100, 32'h0,        32'h00000000, 1'b1, 1, 0, 32'h345612EF};
      vt[11] = '{1'b1, 3'd4, 32'h100, 32'h55,       32'h00000000, 1'b1, 1, 0, 32'h345612EF};
      vt[12] = '{1'b1, 3'd1, 32'h103, 32'h7777,     32'h00000000, 1'b1, 1, 0, 32'h345612EF};
      vt[13] = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h345612EF, 1'b0, 1, 0, 32'h345612EF};
      vt[14] = '{1'b0, 3'd0, 32'h100, 32'h0,        32'hFFFFFFEF, 1'b0, 1, 0, 32'h345612EF};
      vt[15] = '{1'b0, 3'd4, 32'h101, 32'h0,        32'h00000012, 1'b0, 1, 0, 32'h345612EF};
      vt[16] = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h00003456, 1'b0, 1, 0, 32'h345612EF};

      // back-to-back alternating SW/LW
      bb[0] = '{1'b1, 3'd2, 32'h200, 32'h11110000, 32'h0,        1'b0, 1, 1, 32'h0};
      bb[1] = '{1'b0, 3'd2, 32'h200, 32'h0,        32'h11110000, 1'b0, 1, 0, 32'h0};
      bb[2] = '{1'b1, 3'd2, 32'h204, 32'h22220001, 32'h0,        1'b0, 1, 1, 32'h0};
      bb[3] = '{1'b0, 3'd2, 32'h204, 32'h0,        32'h22220001, 1'b0, 1, 0, 32'h0};
      bb[4] = '{1'b1, 3'd2, 32'h200, 32'h33330002, 32'h0,        1'b0, 1, 1, 32'h0};
      bb[5] = '{1'b0, 3'd2, 32'h200, 32'h0,        32'h33330002, 1'b0, 1, 0, 32'h0};

      // reset state, with a live SW presented to prove the write is gated
      rst_n = 1'b0;
      drive(vt[0]);
      req_valid = 1'b1;
      #3;
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst rdata", resp_rdata, 32'd0);
      chk("rst fault", 32'(resp_fault), 32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst wen", 32'(mem_write_en), 32'd0);
      repeat (3) @(negedge clk);
      chk("rst no write", 32'(wr_cnt), 32'd0);
      scramble();
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // reset during RMW_WRITE of SB 0xAA @0x104
      mem[16'h41] = 32'h11223344;
      @(posedge clk); #1;
      req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h104; req_wdata = 32'hAA;
      req_valid = 1'b1;
      @(negedge clk);
      chk("rmwrst ready", 32'(req_ready), 32'd1);
      wr0 = wr_cnt;
      @(posedge clk); #1;
      scramble();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rmwrst wen", 32'(mem_write_en), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rmwrst resp_valid", 32'(resp_valid), 32'd0);
         chk("rmwrst req_ready", 32'(req_ready), 32'd0);
      end
      chk("rmwrst writes", 32'(wr_cnt - wr0), 32'd0);
      chk("rmwrst word", mem[16'h41], 32'h11223344);
      rst_n = 1'b1;
      run_vec('{1'b0, 3'd2, 32'h104, 32'h0,  32'h11223344, 1'b0, 1, 0, 32'h11223344}, "post_rst lw");
      run_vec('{1'b1, 3'd0, 32'h104, 32'hAA, 32'h0,        1'b0, 2, 1, 32'h112233AA}, "post_rst sb");

      // back-to-back with req_valid held high
      idx = 0; nresp = 0; cyc = 0; last_acc = -1;
      @(posedge clk); #1;
      drive(bb[0]);
      req_valid = 1'b1;
      while ((idx < 6 || nresp < 6) && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (resp_valid) begin
            chk("b2b ready_in_resp", 32'(req_ready), 32'd0);
            if (sb_q.size() == 0) fail_now("b2b unexpected resp");
            else begin
               e = sb_q.pop_front();
               chk("b2b rdata", resp_rdata, e[32:1]);
               chk("b2b fault", 32'(resp_fault), 32'(e[0]));
            end
            nresp++;
         end
         acc = req_valid && req_ready;
         if (acc) begin
            if (last_acc >= 0) chk("b2b spacing", 32'(cyc - last_acc), 32'd2);
            last_acc = cyc;
            sb_q.push_back({bb[idx].exp_rd, bb[idx].exp_f});
            idx++;
         end
         @(posedge clk); #1;
         if (acc) begin
            if (idx < 6) drive(bb[idx]);
            else scramble();
         end
      end
      if (cyc >= 40) fail_now("b2b");
      chk("b2b accepts", 32'(idx), 32'd6);
      chk("b2b resps", 32'(nresp), 32'd6);
      chk("b2b word200", mem[16'h80], 32'h33330002);
      chk("b2b word204", mem[16'h81], 32'h22220001);
      repeat (2) @(negedge clk);
      chk("b2b no extra resp", 32'(resp_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side memory port for the MEM stage of the pipelined RV32I core; sits between the pipeline and the word-addressed, single-port data memory. Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses, sign- or zero-extends load data, and performs sub-word stores as a two-cycle read-modify-write. Detects misaligned and illegal accesses and reports them without touching memory.

## Interface
- ADDR_WIDTH, 16, word-index width of the data memory (depth 2^ADDR_WIDTH words).
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (size/sign).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (rs2, low bytes used for SB/SH).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned or illegal funct3; valid with resp_valid.
- mem_write_en  out  1  data-memory write strobe.
- mem_addr  out  32  word index = zero-extended req_addr[ADDR_WIDTH+1:2].
- mem_write_data  out  32  full word to write.
- mem_read_data  in  32  combinational read data of word at mem_addr.

## Operation
- States: IDLE, RMW_WRITE, RESP. Reset state IDLE.
- req_ready = 1 only in IDLE with rst_n high. Accept = req_valid & req_ready.
- Fault: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; funct3 3,6,7; store with funct3 4,5. On fault: no memory write, resp_rdata=0, resp_fault=1, IDLE -> RESP.
- Load accepted in IDLE: mem_addr from req_addr; byte/halfword selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; result registered into resp_rdata; IDLE -> RESP.
- SW accepted: mem_write_en=1 in the accept cycle, mem_write_data=req_wdata; IDLE -> RESP.
- SB/SH accepted: old word (mem_read_data) merged with req_wdata[7:0] / [15:0] at byte lane addr[1:0], merged word and word index registered; IDLE -> RMW_WRITE.
- RMW_WRITE: mem_write_en=1, mem_addr=latched index, mem_write_data=merged word; -> RESP.
- RESP: resp_valid=1 for exactly one cycle; -> IDLE.
- mem_write_en = 0 in all other cases; mem_addr in RESP holds last latched index (don't-care to memory).

## Timing
- Reset (async): state IDLE, resp_valid=0, resp_rdata=0, resp_fault=0; req_ready and mem_write_en forced 0 while rst_n low.
- Load / SW / fault: resp_valid 1 cycle after accept. SB/SH: 2 cycles after accept.
- Throughput: one request per 2 cycles (word/load), per 3 cycles (sub-word store).
- req_* sampled only in the accept cycle; need not be held afterwards.
- resp_rdata/resp_fault hold their value until the next response is registered.
- Reset asserted during RMW_WRITE: write suppressed, memory keeps old word, no response.
- Back-to-back: req_valid held high during RESP is not accepted until the following IDLE cycle.

## Structure
- Package lsu_pkg: funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5), state enum, fault-check function.
- Sub-module lsu_align (combinational): load extract/extend and store byte-lane merge; top holds FSM, registers and memory muxing.

## Test plan
- Store SW 0xDEADBEEF @0x100, then LW @0x100 -> mem word 0x40 written in accept cycle; load resp_rdata=0xDEADBEEF one cycle after accept, resp_fault=0.
- With word 0x40 = 0xDEADBEEF: LB @0x103 -> 0xFFFFFFDE; LBU @0x103 -> 0x000000DE; LH @0x100 -> 0xFFFFBEEF; LHU @0x102 -> 0x0000DEAD.
- SB 0x12 @0x101 then SH 0x3456 @0x102 on 0xDEADBEEF -> word becomes 0xDEAD12EF then 0x345612EF; each write only in RMW_WRITE, resp_valid 2 cycles after accept.
- SW @0x102, LH @0x101, load funct3=3 -> resp_fault=1, resp_rdata=0, mem_write_en never asserted, memory unchanged.
- Assert rst_n low in RMW_WRITE of SB 0xAA @0x104 -> no write, word unchanged, resp_valid=0, req_ready=0 until release; first request after release completes normally.
- req_valid held high continuously with alternating LW/SW -> exactly one accept per IDLE cycle, req_ready=0 in RESP/RMW_WRITE, no request lost or duplicated.
